// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: PC generator, pipelined imem requester and in-order
// instruction queue feeding decode. Redirect flushes the queue and drops
// responses still in flight.
// Optional feature macro FETCH_PERF_CNT_EN adds perf_stall_cycles and
// perf_redirects saturating counters.

module cpu_fetch_queue #(
   parameter int unsigned     XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter int unsigned     DEPTH           = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc_out
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_stall_cycles,
   output logic [31:0]     perf_redirects
`endif
);

   localparam int unsigned QAW = $clog2(DEPTH);
   localparam int unsigned CW  = QAW + 1;
   localparam int unsigned OW  = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned IAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   // ST_HOLD keeps requests off for the first edge after reset release
   typedef enum logic {ST_HOLD, ST_RUN} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [QAW-1:0]  head_q, head_d;
   logic [QAW-1:0]  tail_q, tail_d;
   logic [OW-1:0]   outstanding_q, outstanding_d;
   logic [OW-1:0]   drop_q, drop_d;
   logic [IAW-1:0]  if_rd_q, if_rd_d;
   logic [IAW-1:0]  if_wr_q, if_wr_d;

   logic [XLEN-1:0] q_data_q [DEPTH];
   logic [XLEN-1:0] q_pc_q   [DEPTH];
   logic [XLEN-1:0] if_pc_q  [MAX_OUTSTANDING];

   logic credit_ok;
   logic req_fire;
   logic rsp_keep;
   logic push;
   logic pop;

   // in-flight PC FIFO pointers wrap at MAX_OUTSTANDING, which need not be a power of two
   function automatic logic [IAW-1:0] if_next(input logic [IAW-1:0] p);
      if (32'(p) == MAX_OUTSTANDING - 1) return '0;
      return p + IAW'(1);
   endfunction

   // head of queue and current fetch address come straight from registers
   always_comb begin
      instr_valid   = (count_q != '0);
      instr         = q_data_q[head_q];
      pc_out        = q_pc_q[head_q];
      imem_req_addr = fetch_pc_q;
   end

   // request credit check and handshake qualifiers
   always_comb begin
      credit_ok      = (32'(outstanding_q) < MAX_OUTSTANDING) &&
                       ((32'(count_q) + 32'(outstanding_q)) < DEPTH);
      imem_req_valid = (state_q == ST_RUN) && !redirect_valid && credit_ok;
      req_fire       = imem_req_valid && imem_req_ready;
      rsp_keep       = imem_rsp_valid && (drop_q == '0);
      push           = rsp_keep && !redirect_valid;
      pop            = instr_valid && instr_ready && !redirect_valid;
   end

   // next-state for PC, queue pointers and request accounting; redirect overrides all
   always_comb begin
      state_d       = ST_RUN;
      fetch_pc_d    = fetch_pc_q;
      count_d       = count_q;
      head_d        = head_q;
      tail_d        = tail_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      if_rd_d       = if_rd_q;
      if_wr_d       = if_wr_q;
      if (redirect_valid) begin
         fetch_pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
         count_d       = '0;
         head_d        = '0;
         tail_d        = '0;
         if_rd_d       = '0;
         if_wr_d       = '0;
         // everything still in flight after this cycle belongs to the old path
         outstanding_d = outstanding_q - OW'(imem_rsp_valid);
         drop_d        = outstanding_d;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            if_wr_d    = if_next(if_wr_q);
         end
         if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - OW'(1);
         end
         if (rsp_keep) begin
            if_rd_d = if_next(if_rd_q);
         end
         if (push) begin
            tail_d = tail_q + QAW'(1);
         end
         if (pop) begin
            head_d = head_q + QAW'(1);
         end
         count_d       = count_q + CW'(push) - CW'(pop);
         outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_rsp_valid);
      end
   end

   // control state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_HOLD;
         fetch_pc_q    <= RESET_PC;
         count_q       <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         if_rd_q       <= '0;
         if_wr_q       <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         count_q       <= count_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         if_rd_q       <= if_rd_d;
         if_wr_q       <= if_wr_d;
      end
   end

   // queue and in-flight PC storage; cleared on reset so instr/pc_out read 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_data_q[i] <= '0;
            q_pc_q[i]   <= '0;
         end
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if_pc_q[i] <= '0;
         end
      end else begin
         if (req_fire) begin
            if_pc_q[if_wr_q] <= fetch_pc_q;
         end
         if (push) begin
            q_data_q[tail_q] <= imem_rsp_data;
            q_pc_q[tail_q]   <= if_pc_q[if_rd_q];
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] redir_q, redir_d;

   // saturating event counters
   always_comb begin
      stall_d = stall_q;
      redir_d = redir_q;
      if (!instr_valid && instr_ready && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
      if (redirect_valid && (redir_q != '1)) begin
         redir_d = redir_q + 32'd1;
      end
   end

   // counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         redir_q <= '0;
      end else begin
         stall_q <= stall_d;
         redir_q <= redir_d;
      end
   end

   assign perf_stall_cycles = stall_q;
   assign perf_redirects    = redir_q;
`else
   // performance counters not built
`endif

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// tb_cpu_fetch_queue: directed + randomized bench with an imem model and a
// PC-stream reference model (epochs mark responses made stale by redirect).

module tb_cpu_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXO  = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_redirects;
`endif

   cpu_fetch_queue #(
      .XLEN(32), .RESET_PC(RPC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .pc_out(pc_out)
`ifdef FETCH_PERF_CNT_EN
      , .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   typedef struct {
      int unsigned ep;
      logic [31:0] addr;
      int unsigned due;
   } req_t;

   req_t        pend[$];
   int          total = 0;
   int          bad   = 0;
   int unsigned cyc = 0, epoch = 0, occ = 0, npop = 0, n_acc = 0;
   int unsigned lat_lo = 1, lat_hi = 1, rdy_pct = 100, irdy_pct = 100;
   logic        started = 1'b0;
   logic [31:0] exp_pc, exp_req, last_pop_pc, last_acc_addr, seed;
   logic [31:0] m_stall, m_redir;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ seed;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: sample just after the negedge, update model, advance, present imem response
   task automatic tick();
      logic rdr, acc, rsp, pop, exp_rv;
      req_t r;
      #1;
      rdr    = redirect_valid;
      acc    = imem_req_valid && imem_req_ready;
      rsp    = imem_rsp_valid;
      pop    = instr_valid && instr_ready && !rdr;
      exp_rv = started && !rdr && (pend.size() < MAXO) && ((occ + pend.size()) < DEPTH);
      chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, occ != 0});
      if (!instr_valid && instr_ready) m_stall++;
      if (rdr) m_redir++;
      if (pop) begin
         chk("pc_out", pc_out, exp_pc);
         chk("instr", instr, mem_word(exp_pc));
         last_pop_pc = pc_out;
         exp_pc += 32'd4;
         npop++;
         occ--;
      end
      if (rsp) begin
         r = pend.pop_front();
         if (!rdr && r.ep == epoch) occ++;
      end
      if (acc) begin
         chk("req_addr", imem_req_addr, exp_req);
         r.ep = epoch; r.addr = imem_req_addr; r.due = cyc + $urandom_range(lat_hi, lat_lo);
         pend.push_back(r);
         last_acc_addr = imem_req_addr;
         exp_req += 32'd4;
         n_acc++;
      end
      if (rdr) begin
         epoch++;
         occ     = 0;
         exp_pc  = redirect_pc & ~32'd3;
         exp_req = redirect_pc & ~32'd3;
      end
      started = 1'b1;
      chk("outstanding_le_max", {31'd0, pend.size() <= MAXO}, 32'd1);
      @(negedge clk);
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
   endtask

   task automatic step();
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      instr_ready    = ($urandom_range(99) < irdy_pct);
      tick();
   endtask

   task automatic do_reset(input logic mid);
      if (mid) #2;
      reset          = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      pend.delete();
      occ = 0; n_acc = 0; npop = 0; started = 1'b0;
      exp_pc = RPC; exp_req = RPC;
      m_stall = '0; m_redir = '0;
      #1;
      chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_perf_stall", perf_stall_cycles, 32'd0);
      chk("rst_perf_redir", perf_redirects, 32'd0);
`endif
      @(negedge clk);
      cyc++;
      reset = 1'b1;
   endtask

   initial begin
      int unsigned n, p0;
      seed           = $urandom;
      reset          = 1'b0;
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      do_reset(1'b0);

      // first instruction latency and back-to-back stream
      n = 0;
      while (instr_valid !== 1'b1 && n < 20) begin step(); n++; end
      chk("first_valid_latency", n, 32'd3);
      for (int i = 0; i < 4; i++) step();
      chk("stream_pops", npop, 32'd4);
      chk("stream_last_pc", last_pop_pc, 32'hC);

      // decode stalled: queue fills to DEPTH, fetch stops, head held
      do_reset(1'b0);
      irdy_pct = 0;
      for (int i = 0; i < 20; i++) step();
      chk("stall_fetched", n_acc, DEPTH);
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("stall_head_pc", pc_out, RPC);
      chk("stall_head_instr", instr, mem_word(RPC));
      irdy_pct = 100;
      n = 0;
      while (n_acc < 5 && n < 20) begin step(); n++; end
      chk("resume_addr", last_acc_addr, 32'h10);
      n = 0;
      while (npop < 4 && n < 20) begin step(); n++; end
      chk("drain_last_pc", last_pop_pc, 32'hC);

      // redirect with two requests outstanding
      lat_lo = 3; lat_hi = 3;
      n = 0;
      while (pend.size() != 2 && n < 50) begin step(); n++; end
      chk("two_outstanding", pend.size(), 32'd2);
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      step();
      redirect_valid = 1'b0;
      p0 = npop; n = 0;
      while (npop == p0 && n < 50) begin step(); n++; end
      chk("redirect_first_pc", last_pop_pc, 32'h100);

      // back-to-back redirects: last one wins
      redirect_valid = 1'b1; redirect_pc = 32'h200; step();
      redirect_pc = 32'h300; step();
      redirect_valid = 1'b0;
      p0 = npop; n = 0;
      while (npop == p0 && n < 50) begin step(); n++; end
      chk("b2b_redirect_pc", last_pop_pc, 32'h300);

      // PC wraps at the top of the address space
      lat_lo = 1; lat_hi = 1;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9; step();
      redirect_valid = 1'b0;
      p0 = npop; n = 0;
      while (npop < p0 + 3 && n < 50) begin step(); n++; end
      chk("wrap_third_pc", last_pop_pc, 32'h0);

      // random traffic with variable latency, backpressure and redirects
      lat_lo = 1; lat_hi = 3; rdy_pct = 50; irdy_pct = 70;
      for (int i = 0; i < 400; i++) begin
         redirect_valid = ($urandom_range(99) < 3);
         redirect_pc    = $urandom;
         step();
      end
      redirect_valid = 1'b0;
      chk("random_progress", {31'd0, npop > 50}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_stall", perf_stall_cycles, m_stall);
      chk("perf_redir", perf_redirects, m_redir);
`endif

      // reset asserted with three instructions queued
      lat_lo = 1; lat_hi = 1; rdy_pct = 100; irdy_pct = 0;
      redirect_valid = 1'b1; redirect_pc = 32'h4000; step();
      redirect_valid = 1'b0;
      n = 0;
      while (occ != 3 && n < 50) begin step(); n++; end
      chk("three_queued", occ, 32'd3);
      do_reset(1'b1);
      irdy_pct = 100;
      n = 0;
      while (npop == 0 && n < 20) begin step(); n++; end
      chk("restart_pc", last_pop_pc, RPC);
      for (int i = 0; i < 10; i++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_fetch_queue.md
Name: cpu_fetch_queue

Overview:
Parametrised successor to the single-instruction fetch stage: generates the PC stream, issues pipelined requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a DEPTH-entry queue. Presents instruction and PC pairs to decode with a valid/ready handshake. Supports branch/jump redirect with flush of the queue and of in-flight responses. Sits between imem and the decode stage.

Parameters:
XLEN, 32, PC and instruction width in bits
RESET_PC, 32'h0000_0000, PC fetched first after reset release
DEPTH, 4, instruction queue entries; power of two, >= 2
MAX_OUTSTANDING, 2, maximum imem requests in flight; 1..DEPTH

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_req_addr  out  XLEN  fetch address, word aligned
imem_rsp_valid  in  1  response valid; responses in request order, >= 1 cycle after acceptance
imem_rsp_data  in  XLEN  instruction word
redirect_valid  in  1  flush and restart at redirect_pc
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (forced 0)
instr_valid  out  1  queue head valid
instr_ready  in  1  decode consumes head
instr  out  XLEN  head instruction
pc_out  out  XLEN  PC of head instruction

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC, queue empty, outstanding=0, drop=0; imem_req_valid=0, instr_valid=0, instr=0, pc_out=0. The first request is issued on the first clk edge after deassertion.
- Request issue: imem_req_valid=1 iff !redirect_valid && outstanding<MAX_OUTSTANDING && (count+outstanding)<DEPTH. This credit check guarantees that every response has a free slot. imem_req_addr=fetch_pc. On an accepted request, fetch_pc+=4 (wraps modulo 2^XLEN) and the PC is pushed into the internal in-flight PC FIFO.
- Response: on imem_rsp_valid, outstanding decrements. If drop>0, the response is discarded and drop decrements. Otherwise {data, pc} from the in-flight FIFO is written to the queue tail.
- Output: instr_valid = count>0. instr and pc_out show the head entry (registered storage, no combinational path from imem_rsp). A pop occurs on instr_valid && instr_ready. The instruction/PC is held stable while instr_valid && !instr_ready.
- Latency: from request acceptance, instr_valid is seen at the earliest 1 cycle after imem_rsp_valid. There is no bypass.
- Simultaneous push+pop when full: cannot occur, because credits prevent pushes into a full queue. Push+pop at count=1 keeps count=1 with the new head.
- Redirect (top priority): on the cycle redirect_valid=1:
  - queue cleared, so instr_valid=0 next cycle
  - fetch_pc = {redirect_pc[XLEN-1:2],2'b00}
  - drop = outstanding minus any response arriving this same cycle
  - the in-flight PC FIFO is cleared
  - no request is issued that cycle
  - a pop in the same cycle is ignored
- Back-to-back redirects: the last one wins; drop is recomputed each time.
- Reset asserted mid-transaction: all state clears immediately. imem must also be reset; late responses after reset are not supported.
- Counters: count is clog2(DEPTH)+1 bits. outstanding and drop are clog2(MAX_OUTSTANDING)+1 bits. A pointer wrap is a natural power-of-two overflow.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles (32 bits) and perf_redirects (32 bits), both reset to 0 and saturating at all-ones.
  - perf_stall_cycles increments each cycle with instr_valid=0 && instr_ready=1.
  - perf_redirects increments each cycle with redirect_valid=1.
- Undefined: both ports and their logic are absent, and the behaviour is otherwise identical.

Test Plan:
- Reset release, imem 1-cycle latency, instr_ready=1 -> pc_out 0x0,0x4,0x8,0xC on consecutive cycles; instr matches memory words; first instr_valid 3 cycles after reset release.
- instr_ready=0 for 20 cycles -> exactly DEPTH=4 entries fetched, imem_req_valid=0 thereafter, head stays pc_out=0x0. On ready=1, the drain order is 0x0..0xC and fetching resumes at 0x10.
- Redirect to 0x103 while 2 requests are outstanding -> next instr has pc_out=0x100, and both stale responses are dropped (never visible on instr).
- imem_req_ready toggling 0/1 plus 3-cycle response latency -> outstanding never exceeds 2; PC order contiguous with no duplicates or gaps.
- Redirect on two consecutive cycles (0x200 then 0x300) -> first delivered pc_out=0x300; no 0x200 instruction appears.
- Reset asserted mid-stream with 3 queued -> instr_valid=0 immediately (asynchronous); after release, pc_out restarts at RESET_PC. With FETCH_PERF_CNT_EN, both counters read 0.
